// File: rtl/usb_tx.sv
// usb_tx: full-speed USB transmitter.
// Serialises SYNC, PID, optional FIFO data and CRC16, with bit stuffing and
// NRZI encoding, then drives EOP onto d_plus/d_minus.
// Optional build macro USB_TX_ZLP_EN: when defined, a DATA0/DATA1 request with
// an empty FIFO sends a zero-length packet instead of raising tx_error.
module usb_tx #(
    parameter int CLKS_PER_BIT   = 4,
    parameter int MAX_DATA_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] tx_packet,
    input  logic [7:0] tx_packet_data,
    input  logic [6:0] buffer_occupancy,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       d_plus,
    output logic       d_minus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(MAX_DATA_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC1, S_CRC2, S_EOP_SE0, S_EOP_J
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_clk_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;     // r_shift[0] is the bit currently on the line
    logic [2:0]      r_ones;      // run of consecutive 1s in the pre-NRZI stream
    logic [15:0]     r_crc;       // bit-reversed register: r_crc[0] holds x^15
    logic [BW-1:0]   r_bytes;
    logic [2:0]      r_code;
    logic            r_get;
    logic            r_active;
    logic            r_err;
    logic            r_dp;
    logic            r_dm;

    logic            w_zlp_block;
    logic            w_is_data_req;
    logic            w_req_reject;
    logic            w_req_accept;
    logic            w_bit_end;
    logic            w_serial;
    logic            w_stuff;
    logic            w_advance;
    logic            w_byte_end;
    logic            w_is_data_pkt;
    logic            w_can_pop;
    logic [7:0]      w_pid_byte;
    state_t          w_next_state;
    logic [7:0]      w_load_byte;
    logic            w_pop;
    logic            w_fire;
    logic            w_bit;
    logic            w_crc_en;
    logic [15:0]     w_crc_next;

`ifdef USB_TX_ZLP_EN
    assign w_zlp_block = 1'b0;
`else
    assign w_zlp_block = (buffer_occupancy == 7'd0);
`endif

    // Request decode: codes 6/7 and (without ZLP) empty-FIFO data requests are rejected.
    always_comb begin
        w_is_data_req = (tx_packet == 3'd1) || (tx_packet == 3'd2);
        w_req_reject  = (tx_packet[2:1] == 2'b11) || (w_is_data_req && w_zlp_block);
        w_req_accept  = (tx_packet != 3'd0) && !w_req_reject;
    end

    // Bit timing and packet-level helpers.
    always_comb begin
        w_bit_end     = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
        w_serial      = r_state inside {S_SYNC, S_PID, S_DATA, S_CRC1, S_CRC2};
        w_stuff       = w_bit_end && w_serial && (r_ones == 3'd6);
        w_advance     = w_bit_end && w_serial && (r_ones != 3'd6);
        w_byte_end    = w_advance && (r_bit_cnt == 3'd7);
        w_is_data_pkt = (r_code == 3'd1) || (r_code == 3'd2);
        w_can_pop     = (buffer_occupancy != 7'd0) && (r_bytes < BW'(MAX_DATA_BYTES));
        case (r_code)
            3'd1:    w_pid_byte = 8'hC3;
            3'd2:    w_pid_byte = 8'h4B;
            3'd3:    w_pid_byte = 8'hD2;
            3'd4:    w_pid_byte = 8'h5A;
            default: w_pid_byte = 8'h1E;
        endcase
    end

    // Byte-boundary decision: which field follows and which byte it loads.
    always_comb begin
        w_next_state = r_state;
        w_load_byte  = 8'h00;
        w_pop        = 1'b0;
        if (w_byte_end) begin
            case (r_state)
                S_SYNC: begin
                    w_next_state = S_PID;
                    w_load_byte  = w_pid_byte;
                end
                S_PID, S_DATA: begin
                    if (r_state == S_PID && !w_is_data_pkt) begin
                        w_next_state = S_EOP_SE0;
                    end else if (w_can_pop) begin
                        w_next_state = S_DATA;
                        w_load_byte  = tx_packet_data;
                        w_pop        = 1'b1;
                    end else begin
                        w_next_state = S_CRC1;
                        w_load_byte  = ~r_crc[7:0];
                    end
                end
                S_CRC1: begin
                    w_next_state = S_CRC2;
                    w_load_byte  = ~r_crc[15:8];
                end
                default: w_next_state = S_EOP_SE0;
            endcase
        end
    end

    // Which pre-NRZI bit (if any) starts on this edge, and whether it feeds the CRC.
    always_comb begin
        w_fire = 1'b0;
        w_bit  = 1'b0;
        if (r_state == S_IDLE) begin
            w_fire = w_req_accept;          // first SYNC bit is a 0
        end else if (w_stuff) begin
            w_fire = 1'b1;
        end else if (w_advance) begin
            if (r_bit_cnt != 3'd7) begin
                w_fire = 1'b1;
                w_bit  = r_shift[1];
            end else if (w_next_state != S_EOP_SE0) begin
                w_fire = 1'b1;
                w_bit  = w_load_byte[0];
            end
        end
        w_crc_en   = w_advance && (((r_bit_cnt != 3'd7) && (r_state == S_DATA)) ||
                                   ((r_bit_cnt == 3'd7) && (w_next_state == S_DATA)));
        w_crc_next = {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ w_bit) ? 16'hA001 : 16'h0000);
    end

    // Transmit FSM: serialiser, stuffing run counter, CRC, NRZI line and strobes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_ones    <= 3'd0;
            r_crc     <= 16'hFFFF;
            r_bytes   <= '0;
            r_code    <= 3'd0;
            r_get     <= 1'b0;
            r_active  <= 1'b0;
            r_err     <= 1'b0;
            r_dp      <= 1'b1;
            r_dm      <= 1'b0;
        end else begin
            r_get     <= w_pop;
            r_err     <= (r_state == S_IDLE) && (tx_packet != 3'd0) && w_req_reject;
            r_clk_cnt <= ((r_state == S_IDLE) || w_bit_end) ? '0 : r_clk_cnt + 1'b1;
            if (w_fire) begin
                if (!w_bit) begin
                    r_dp   <= ~r_dp;        // NRZI: a 0 toggles the line
                    r_dm   <= r_dp;
                    r_ones <= 3'd0;
                end else begin
                    r_ones <= r_ones + 3'd1;
                end
            end
            if (w_crc_en) begin
                r_crc <= w_crc_next;
            end
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= 3'd0;
                    r_bytes   <= '0;
                    r_crc     <= 16'hFFFF;
                    if (w_req_accept) begin
                        r_code   <= tx_packet;
                        r_state  <= S_SYNC;
                        r_active <= 1'b1;
                        r_shift  <= 8'h80;
                    end
                end
                S_EOP_SE0: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt[0]) begin
                            r_state   <= S_EOP_J;
                            r_bit_cnt <= 3'd0;
                            r_dp      <= 1'b1;
                            r_dm      <= 1'b0;
                        end else begin
                            r_bit_cnt <= 3'd1;
                        end
                    end
                end
                S_EOP_J: begin
                    if (w_bit_end) begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    // A stuffed bit leaves the bit counter and shifter untouched.
                    if (w_advance) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= w_next_state;
                            r_shift <= w_load_byte;
                            if (w_pop) begin
                                r_bytes <= r_bytes + 1'b1;
                            end
                            if (w_next_state == S_EOP_SE0) begin
                                r_dp <= 1'b0;
                                r_dm <= 1'b0;
                            end
                        end else begin
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end
                end
            endcase
        end
    end

    assign get_tx_packet_data = r_get;
    assign tx_transfer_active = r_active;
    assign tx_error           = r_err;
    assign d_plus             = r_dp;
    assign d_minus            = r_dm;

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: directed bench for usb_tx. A line receiver samples each bit time,
// undoes NRZI and stuffing, and compares against hand-computed fields, an
// expected-payload queue and a CRC16 reference model.
`timescale 1ns/1ps
module tb_usb_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [2:0] tx_packet;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       get_tx_packet_data;
    logic       tx_transfer_active;
    logic       tx_error;
    logic       d_plus;
    logic       d_minus;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [1:0] sym_q[$];
    logic       bits_q[$];
    logic [7:0] byte_q[$];
    int act_clks, pop_cnt, se0_clks, j_tail_clks, stuff_cnt, first_stuff, bad_stuff;

    usb_tx #(.CLKS_PER_BIT(CPB), .MAX_DATA_BYTES(64)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .d_plus             (d_plus),
        .d_minus            (d_minus)
    );

    // Clock.
    always #5 clk = ~clk;

    // Show-ahead FIFO model, updated away from the active edge.
    always @(negedge clk) begin
        logic [7:0] dummy;
        if (get_tx_packet_data && fifo_q.size() > 0) dummy = fifo_q.pop_front();
        buffer_occupancy = 7'(fifo_q.size());
        tx_packet_data   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference CRC16 (non-reflected form) over the first n bytes of exp_q, LSB first.
    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[15] ^ exp_q[i][j];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    // Issue a request, record the line once per bit time, then decode it.
    task automatic capture(input logic [2:0] code);
        int         clk_i;
        int         ones;
        int         raw_i;
        bit         done;
        logic [1:0] prev;
        logic       b;
        logic [7:0] acc;
        sym_q.delete(); bits_q.delete(); byte_q.delete();
        act_clks = 0; pop_cnt = 0; se0_clks = 0; j_tail_clks = 0;
        stuff_cnt = 0; first_stuff = -1; bad_stuff = 0;
        @(negedge clk); tx_packet = code;
        @(negedge clk); tx_packet = 3'd0;
        clk_i = 0;
        while (tx_transfer_active === 1'b1 && clk_i < 20000) begin
            act_clks++;
            if (get_tx_packet_data) pop_cnt++;
            if (!d_plus && !d_minus) se0_clks++;
            else if (se0_clks > 0 && d_plus && !d_minus) j_tail_clks++;
            if (clk_i % CPB == 0) sym_q.push_back({d_plus, d_minus});
            clk_i++;
            @(negedge clk);
        end
        check("capture_bounded", 32'(clk_i < 20000), 1);
        prev = 2'b10; ones = 0; raw_i = 0; done = 0;
        for (int i = 0; i < sym_q.size(); i++) begin
            if (!done) begin
                if (sym_q[i] == 2'b00) begin
                    done = 1;
                end else begin
                    b    = (sym_q[i] == prev);
                    prev = sym_q[i];
                    if (ones == 6) begin
                        stuff_cnt++;
                        if (first_stuff < 0) first_stuff = raw_i;
                        if (b) bad_stuff++;
                        ones = 0;
                    end else begin
                        bits_q.push_back(b);
                        ones = b ? ones + 1 : 0;
                    end
                    raw_i++;
                end
            end
        end
        for (int i = 0; i + 8 <= bits_q.size(); i += 8) begin
            for (int j = 0; j < 8; j++) acc[j] = bits_q[i + j];
            byte_q.push_back(acc);
        end
    endtask

    // Field-level checks of the last captured frame.
    task automatic check_frame(input string tag, input logic [7:0] pid, input bit is_data);
        int          n_pay;
        int          mism;
        logic [15:0] c;
        logic [15:0] exp_word;
        logic [15:0] got_word;
        n_pay = is_data ? exp_q.size() : 0;
        check({tag, "_len"}, byte_q.size(), n_pay + 2 + (is_data ? 2 : 0));
        check({tag, "_align"}, bits_q.size() % 8, 0);
        check({tag, "_sync"}, byte_q[0], 8'h80);
        check({tag, "_pid"}, byte_q[1], pid);
        check({tag, "_se0_clks"}, se0_clks, 2 * CPB);
        check({tag, "_j_clks"}, j_tail_clks, CPB);
        check({tag, "_bad_stuff"}, bad_stuff, 0);
        check({tag, "_end_line"}, {d_plus, d_minus}, 2'b10);
        if (is_data) begin
            mism = 0;
            for (int i = 0; i < n_pay; i++) if (byte_q[2 + i] !== exp_q[i]) mism++;
            check({tag, "_payload"}, mism, 0);
            c = crc_model(n_pay);
            for (int i = 0; i < 16; i++) exp_word[i] = ~c[15 - i];
            got_word = {byte_q[n_pay + 3], byte_q[n_pay + 2]};
            check({tag, "_crc"}, got_word, exp_word);
        end
    endtask

    // A request that must be refused: one tx_error pulse, no line activity.
    task automatic idle_request(input logic [2:0] code, input string tag);
        int errs;
        int act;
        int notj;
        errs = 0; act = 0; notj = 0;
        @(negedge clk); tx_packet = code;
        @(negedge clk); tx_packet = 3'd0;
        repeat (12) begin
            if (tx_error) errs++;
            if (tx_transfer_active) act++;
            if (!(d_plus && !d_minus)) notj++;
            @(negedge clk);
        end
        check({tag, "_err_pulse"}, errs, 1);
        check({tag, "_active"}, act, 0);
        check({tag, "_line_j"}, notj, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        n_rst = 1'b0;
        tx_packet = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_dp", d_plus, 1);
        check("rst_dm", d_minus, 0);
        check("rst_active", tx_transfer_active, 0);
        check("rst_get", get_tx_packet_data, 0);
        check("rst_err", tx_error, 0);
        n_rst = 1'b1;

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (d_plus !== 1'b1 || d_minus !== 1'b0 || tx_transfer_active !== 1'b0 ||
                get_tx_packet_data !== 1'b0 || tx_error !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);

        // ACK: 16 bits + 3 EOP bit times = 76 clocks.
        capture(3'd3);
        check("ack_active_clks", act_clks, 76);
        check("ack_pops", pop_cnt, 0);
        check("ack_stuffs", stuff_cnt, 0);
        check_frame("ack", 8'hD2, 1'b0);

        // DATA0 with a single 0xFF: stuff after the 4th data bit (raw index 20).
        fifo_q.push_back(8'hFF);
        exp_q.delete(); exp_q.push_back(8'hFF);
        repeat (2) @(negedge clk);
        capture(3'd1);
        check("d0ff_pops", pop_cnt, 1);
        check("d0ff_stuff_pos", first_stuff, 20);
        check("d0ff_fifo_left", fifo_q.size(), 0);
        check_frame("d0ff", 8'hC3, 1'b1);

        // DATA1 with 70 bytes queued: only 64 leave.
        exp_q.delete();
        for (int i = 0; i < 70; i++) begin
            fifo_q.push_back(8'((i * 7 + 3) & 8'hFF));
            if (i < 64) exp_q.push_back(8'((i * 7 + 3) & 8'hFF));
        end
        repeat (2) @(negedge clk);
        capture(3'd2);
        check("d1max_pops", pop_cnt, 64);
        check("d1max_fifo_left", fifo_q.size(), 6);
        check("d1max_fifo_head", fifo_q[0], 8'((64 * 7 + 3) & 8'hFF));
        check_frame("d1max", 8'h4B, 1'b1);
        fifo_q.delete();
        repeat (2) @(negedge clk);

        // Empty-FIFO data request.
        exp_q.delete();
`ifdef USB_TX_ZLP_EN
        capture(3'd1);
        check("zlp_pops", pop_cnt, 0);
        check("zlp_crc_word", {byte_q[3], byte_q[2]}, 16'h0000);
        check_frame("zlp", 8'hC3, 1'b1);
`else
        idle_request(3'd1, "zlp_reject");
`endif

        // Invalid code.
        idle_request(3'd7, "code7");

        // Reset in the middle of a DATA packet.
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'hA0 + i));
        repeat (2) @(negedge clk);
        @(negedge clk); tx_packet = 3'd1;
        @(negedge clk); tx_packet = 3'd0;
        repeat (150) @(negedge clk);
        check("mid_active", tx_transfer_active, 1);
        n_rst = 1'b0;
        #1;
        check("midrst_dp", d_plus, 1);
        check("midrst_dm", d_minus, 0);
        check("midrst_active", tx_transfer_active, 0);
        check("midrst_get", get_tx_packet_data, 0);
        @(negedge clk);
        n_rst = 1'b1;
        fifo_q.delete();
        repeat (3) @(negedge clk);

        // Normal ACK afterwards.
        capture(3'd3);
        check("ack2_active_clks", act_clks, 76);
        check_frame("ack2", 8'hD2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
